// File: rtl/ov7670_pkg.sv
// Shared types and luma constants for the OV7670 capture front end.
package ov7670_pkg;

    typedef enum logic {
        MODE_YUV_Y  = 1'b0,
        MODE_RGB565 = 1'b1
    } capture_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        ACTIVE,
        DONE
    } capture_state_e;

    // BT.601-style luma weights scaled by 256; they sum to 256.
    localparam logic [7:0] LumaCoefR = 8'd77;
    localparam logic [7:0] LumaCoefG = 8'd150;
    localparam logic [7:0] LumaCoefB = 8'd29;

endpackage

// File: rtl/rgb565_to_gray.sv
// RGB565 to grayscale converter with one registered stage; keeps the DATA_W MSBs of 8-bit luma.
module rgb565_to_gray
    import ov7670_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [15:0]       pix_i,
    output logic [DATA_W-1:0] gray_o
);

    logic [7:0]        r8, g8, b8;
    logic [15:0]       sum;
    logic [DATA_W-1:0] gray_q;

    // Replicate MSBs so full-scale channels map to 255.
    always_comb begin
        r8  = {pix_i[15:11], pix_i[15:13]};
        g8  = {pix_i[10:5], pix_i[10:9]};
        b8  = {pix_i[4:0], pix_i[4:2]};
        sum = 16'(r8) * 16'(LumaCoefR) + 16'(g8) * 16'(LumaCoefG) + 16'(b8) * 16'(LumaCoefB);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gray_q <= '0;
        end else begin
            gray_q <= sum[15 -: DATA_W];
        end
    end

    assign gray_o = gray_q;

endmodule

// File: rtl/ov7670_capture_scaled.sv
// OV7670 capture: byte pairing, grayscale conversion, 1/2/4/8 decimation and linear
// frame-buffer writes with per-frame status.
module ov7670_capture_scaled
    import ov7670_pkg::*;
#(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 8
) (
    input  logic              pclk_i,
    input  logic              rst_i,
    input  logic              vsync_i,
    input  logic              href_i,
    input  logic [7:0]        din_i,
    input  logic              enable_i,
    input  logic [1:0]        mode_i,
    input  logic [1:0]        scale_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] dout_o,
    output logic              we_o,
    output logic              frame_done_o,
    output logic              frame_err_o,
    output logic [7:0]        frame_cnt_o
);

    localparam int unsigned ColW = $clog2(WIDTH + 1);
    localparam int unsigned RowW = $clog2(HEIGHT + 1);
    localparam int unsigned CntW = ADDR_W + 1;
    localparam logic [CntW-1:0] MaxAddr = CntW'(WIDTH * HEIGHT - 1);

    capture_state_e    state_q;
    capture_mode_e     mode_q;
    logic [1:0]        scale_q;
    logic              vsync_q, href_q, phase_q;
    logic [7:0]        byte0_q;
    logic [ColW-1:0]   col_q;
    logic [RowW-1:0]   row_q;
    logic              s1_valid_q, s2_valid_q;
    logic [15:0]       s1_pix_q;
    logic [7:0]        y_q;
    logic [CntW-1:0]   wr_ptr_q, acc_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dout_q;
    logic              we_q, frame_done_q, frame_err_q;
    logic [7:0]        frame_cnt_q;

    logic              vsync_rise, vsync_fall, href_fall, pix_done, start_frame, keep, wr_ok;
    logic [2:0]        scale_mask;
    logic [CntW-1:0]   expected_cnt;
    logic [DATA_W-1:0] rgb_gray, gray_s2;

    always_comb begin
        vsync_rise   = vsync_i & ~vsync_q;
        vsync_fall   = ~vsync_i & vsync_q;
        href_fall    = href_q & ~href_i;
        pix_done     = href_i & phase_q;
        start_frame  = (state_q == WAIT_START) && vsync_fall && enable_i;
        scale_mask   = 3'((4'd1 << scale_q) - 4'd1);
        keep         = (state_q == ACTIVE) && !vsync_i && pix_done
                       && (col_q < ColW'(WIDTH)) && (row_q < RowW'(HEIGHT))
                       && ((col_q[2:0] & scale_mask) == 3'd0)
                       && ((row_q[2:0] & scale_mask) == 3'd0);
        expected_cnt = (CntW'(WIDTH) >> scale_q) * (CntW'(HEIGHT) >> scale_q);
        wr_ok        = s2_valid_q && (wr_ptr_q <= MaxAddr);
        gray_s2      = (mode_q == MODE_RGB565) ? rgb_gray : y_q[7 -: DATA_W];
    end

    rgb565_to_gray #(
        .DATA_W (DATA_W)
    ) u_rgb565_to_gray (
        .clk_i  (pclk_i),
        .rst_i  (rst_i),
        .pix_i  (s1_pix_q),
        .gray_o (rgb_gray)
    );

    // Byte pairing and line/row position; counters saturate so oversize lines never re-enter range.
    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            phase_q <= 1'b0;
            byte0_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            vsync_q <= vsync_i;
            href_q  <= href_i;
            if (href_i) begin
                phase_q <= ~phase_q;
                if (!phase_q) begin
                    byte0_q <= din_i;
                end
            end else begin
                phase_q <= 1'b0;
            end
            if (vsync_i) begin
                col_q <= '0;
                row_q <= '0;
            end else if (href_fall) begin
                col_q <= '0;
                if (row_q < RowW'(HEIGHT)) begin
                    row_q <= row_q + RowW'(1);
                end
            end else if (pix_done && (col_q < ColW'(WIDTH))) begin
                col_q <= col_q + ColW'(1);
            end
        end
    end

    // Three-register pixel pipeline: pair capture, luma, frame-buffer write.
    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            dout_q     <= '0;
            wr_ptr_q   <= '0;
            acc_cnt_q  <= '0;
        end else begin
            s1_valid_q <= keep;
            if (pix_done) begin
                s1_pix_q <= {byte0_q, din_i};
            end
            s2_valid_q <= s1_valid_q;
            y_q        <= s1_pix_q[15:8];
            we_q       <= wr_ok;
            // Counted at admission so pixels still draining are included in the frame check.
            if (start_frame) begin
                acc_cnt_q <= '0;
            end else if (keep) begin
                acc_cnt_q <= acc_cnt_q + CntW'(1);
            end
            if (wr_ok) begin
                addr_q   <= wr_ptr_q[ADDR_W-1:0];
                dout_q   <= gray_s2;
                wr_ptr_q <= wr_ptr_q + CntW'(1);
            end else if ((state_q == IDLE || state_q == WAIT_START)
                         && !s1_valid_q && !s2_valid_q) begin
                addr_q   <= '0;
                wr_ptr_q <= '0;
            end
        end
    end

    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            mode_q       <= MODE_YUV_Y;
            scale_q      <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (vsync_i) begin
                        state_q <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (start_frame) begin
                        state_q <= ACTIVE;
                        mode_q  <= (mode_i == 2'd1) ? MODE_RGB565 : MODE_YUV_Y;
                        scale_q <= scale_i;
                    end
                end
                ACTIVE: begin
                    if (vsync_rise) begin
                        state_q      <= DONE;
                        frame_done_q <= 1'b1;
                        frame_err_q  <= (acc_cnt_q != expected_cnt);
                        frame_cnt_q  <= frame_cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q <= WAIT_START;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign addr_o       = addr_q;
    assign dout_o       = dout_q;
    assign we_o         = we_q;
    assign frame_done_o = frame_done_q;
    assign frame_err_o  = frame_err_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_ov7670_capture_scaled.sv
// Directed bench for ov7670_capture_scaled on a 16x8 sensor; a monitor logs writes and frame status.
module tb_ov7670_capture_scaled;

    localparam int W = 16;
    localparam int H = 8;

    logic       pclk, rst, vsync, href, enable, we, frame_done, frame_err;
    logic [7:0] din, dout, frame_cnt;
    logic [1:0] mode, scale;
    logic [6:0] addr;

    int n_checks = 0;
    int n_pass   = 0;

    int pat = 0;
    logic [15:0] rgb_tbl [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};

    logic [7:0] mem [0:127];
    int wr_total = 0, fw = 0, seq_bad = 0, last_addr = -1;
    int done_pulses = 0, done_writes = 0, done_err = 0, err_stray = 0;

    ov7670_capture_scaled #(
        .WIDTH  (W),
        .HEIGHT (H),
        .ADDR_W (7),
        .DATA_W (8)
    ) dut (
        .pclk_i       (pclk),
        .rst_i        (rst),
        .vsync_i      (vsync),
        .href_i       (href),
        .din_i        (din),
        .enable_i     (enable),
        .mode_i       (mode),
        .scale_i      (scale),
        .addr_o       (addr),
        .dout_o       (dout),
        .we_o         (we),
        .frame_done_o (frame_done),
        .frame_err_o  (frame_err),
        .frame_cnt_o  (frame_cnt)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Write monitor: sampled 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge pclk);
            #1;
            if (rst) begin
                fw = 0;
            end else begin
                if (we) begin
                    if (int'(addr) != fw) seq_bad++;
                    mem[addr] = dout;
                    last_addr = int'(addr);
                    fw++;
                    wr_total++;
                end
                if (frame_done) begin
                    done_pulses++;
                    done_writes = fw;
                    done_err    = int'(frame_err);
                    fw          = 0;
                end else if (frame_err) begin
                    err_stray++;
                end
            end
        end
    end

    function automatic logic [7:0] byte_at(input int b);
        int          c;
        logic [15:0] w;
        c = b / 2;
        if (pat == 1) w = rgb_tbl[c % 4];
        else          w = {8'(c), 8'h80};
        return (b % 2 == 0) ? w[15:8] : w[7:0];
    endfunction

    task automatic run_frame(input int lines, input int bpl, input int chg_line,
                             input logic [1:0] chg_scale, input int rst_line);
        vsync = 1'b1;
        href  = 1'b0;
        repeat (4) @(negedge pclk);
        vsync = 1'b0;
        repeat (3) @(negedge pclk);
        for (int l = 0; l < lines; l++) begin
            if (l == chg_line) scale = chg_scale;
            if (l == rst_line) begin
                rst = 1'b1;
                #1;
                check_eq("rst_addr", int'(addr), 0);
                check_eq("rst_dout", int'(dout), 0);
                check_eq("rst_we", int'(we), 0);
                check_eq("rst_cnt", int'(frame_cnt), 0);
                check_eq("rst_done", int'(frame_done), 0);
                @(negedge pclk);
                rst = 1'b0;
            end
            for (int b = 0; b < bpl; b++) begin
                href = 1'b1;
                din  = byte_at(b);
                @(negedge pclk);
            end
            href = 1'b0;
            din  = 8'h00;
            repeat (4) @(negedge pclk);
        end
        vsync = 1'b1;
        repeat (6) @(negedge pclk);
    endtask

    int w0, d0;

    initial begin
        rst = 1'b1; vsync = 1'b0; href = 1'b0; din = 8'h00;
        enable = 1'b1; mode = 2'd0; scale = 2'd0;
        repeat (3) @(negedge pclk);
        check_eq("reset_addr", int'(addr), 0);
        check_eq("reset_we", int'(we), 0);
        check_eq("reset_cnt", int'(frame_cnt), 0);
        rst = 1'b0;

        // Mode 0, 1:1 ramp
        w0 = wr_total; d0 = done_pulses;
        run_frame(H, 2 * W, -1, 2'd0, -1);
        check_eq("f1_writes", wr_total - w0, 128);
        check_eq("f1_last", last_addr, 127);
        check_eq("f1_done", done_pulses - d0, 1);
        check_eq("f1_err", done_err, 0);
        check_eq("f1_cnt", int'(frame_cnt), 1);
        check_eq("f1_mem5", int'(mem[5]), 5);
        check_eq("f1_mem37", int'(mem[37]), 5);
        check_eq("f1_mem127", int'(mem[127]), 15);

        // Mode 1, RGB565 primaries and white
        mode = 2'd1; pat = 1;
        run_frame(H, 2 * W, -1, 2'd0, -1);
        check_eq("f2_red", int'(mem[0]), 'h4C);
        check_eq("f2_green", int'(mem[1]), 'h95);
        check_eq("f2_blue", int'(mem[2]), 'h1C);
        check_eq("f2_white", int'(mem[3]), 'hFF);
        check_eq("f2_mem18", int'(mem[18]), 'h1C);
        check_eq("f2_cnt", int'(frame_cnt), 2);

        // 1:4 decimation
        mode = 2'd0; pat = 0; scale = 2'd2;
        w0 = wr_total; d0 = done_pulses;
        run_frame(H, 2 * W, -1, 2'd0, -1);
        check_eq("f3_writes", wr_total - w0, 8);
        check_eq("f3_last", last_addr, 7);
        check_eq("f3_done", done_pulses - d0, 1);
        check_eq("f3_err", done_err, 0);
        check_eq("f3_mem1", int'(mem[1]), 4);
        check_eq("f3_mem7", int'(mem[7]), 12);
        check_eq("f3_cnt", int'(frame_cnt), 3);

        // Truncated frame, reserved mode 2 behaves as Y
        mode = 2'd2; scale = 2'd0;
        w0 = wr_total;
        run_frame(5, 2 * W, -1, 2'd0, -1);
        check_eq("f4_writes", wr_total - w0, 80);
        check_eq("f4_err", done_err, 1);
        check_eq("f4_mem20", int'(mem[20]), 4);

        // Scale change mid-frame is deferred to the next frame
        mode = 2'd0;
        w0 = wr_total;
        run_frame(H, 2 * W, 3, 2'd3, -1);
        check_eq("f5_writes", wr_total - w0, 128);
        check_eq("f5_err", done_err, 0);
        w0 = wr_total;
        run_frame(H, 2 * W, -1, 2'd0, -1);
        check_eq("f6_writes", wr_total - w0, 2);
        check_eq("f6_mem1", int'(mem[1]), 8);
        check_eq("f6_last", last_addr, 1);
        check_eq("f6_cnt", int'(frame_cnt), 6);

        // Odd byte count per line
        scale = 2'd0;
        w0 = wr_total;
        run_frame(H, 2 * W + 1, -1, 2'd0, -1);
        check_eq("f7_writes", wr_total - w0, 128);
        check_eq("f7_mem16", int'(mem[16]), 0);
        check_eq("f7_mem17", int'(mem[17]), 1);

        // Capture disabled
        enable = 1'b0;
        w0 = wr_total; d0 = done_pulses;
        run_frame(H, 2 * W, -1, 2'd0, -1);
        check_eq("f8_writes", wr_total - w0, 0);
        check_eq("f8_done", done_pulses - d0, 0);
        check_eq("f8_cnt", int'(frame_cnt), 7);
        enable = 1'b1;

        // Reset at line 3: only the first 3 lines are written
        w0 = wr_total; d0 = done_pulses;
        run_frame(H, 2 * W, -1, 2'd0, 3);
        check_eq("f9_writes", wr_total - w0, 48);
        check_eq("f9_done", done_pulses - d0, 0);

        w0 = wr_total;
        run_frame(H, 2 * W, -1, 2'd0, -1);
        check_eq("f10_writes", wr_total - w0, 128);
        check_eq("f10_err", done_err, 0);
        check_eq("f10_cnt", int'(frame_cnt), 1);
        check_eq("f10_mem127", int'(mem[127]), 15);
        check_eq("seq_addr", seq_bad, 0);
        check_eq("stray_err", err_stray, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
